// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter with a bounded hold time.
// Shares one resource among four requesters. A tenure ends when the owner
// drops its request, when it has held the grant for MAX_HOLD cycles, or
// when ena falls. On release, priority rotates to the owner's successor,
// and a pending requester takes over on the next cycle with no bubble.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous, active-low reset
//   ena       - enable; 0 releases the current grant and blocks new ones
//   req[3:0]  - request vector, bit i = requester i
//   gnt[3:0]  - one-hot grant (decode of gnt_idx when gnt_valid, else 0)
//   gnt_idx   - index of current owner, 0 when idle
//   gnt_valid - a grant is held
//   timeout   - one-cycle pulse: previous tenure was cut off by MAX_HOLD
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   prio_q, prio_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;

    logic [IDX_W-1:0]   owner_c;
    logic               at_max_c;
    logic               release_c;
    logic [IDX_W-1:0]   search_base_c;
    logic [IDX_W-1:0]   winner_c;

    // First requester found searching p, p+1, p+2, p+3 (mod 4).
    // Scanning from the far end lets the nearest hit overwrite the result.
    function automatic logic [IDX_W-1:0] find_winner(
        input logic [N_REQ-1:0] r,
        input logic [IDX_W-1:0] p
    );
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] idx;
        w = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = p + IDX_W'(k);
            if (r[idx]) begin
                w = idx;
            end
        end
        return w;
    endfunction

    // Release detection for the current owner.
    always_comb begin
        owner_c   = gnt_idx_q;
        at_max_c  = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
        release_c = !req[owner_c] || at_max_c || !ena;
    end

    // Search starts at prio when idle, or at owner+1 on a release.
    always_comb begin
        search_base_c = (state_q == BUSY) ? (owner_c + IDX_W'(1)) : prio_q;
        winner_c      = find_winner(req, search_base_c);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (ena && (req != '0)) begin
                    state_d     = BUSY;
                    gnt_idx_d   = winner_c;
                    gnt_valid_d = 1'b1;
                end else begin
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            BUSY: begin
                if (release_c) begin
                    prio_d     = owner_c + IDX_W'(1);
                    hold_cnt_d = '0;
                    // Only a hold-limit cut of a still-requesting owner counts.
                    timeout_d  = at_max_c && req[owner_c] && ena;
                    if (ena && (req != '0)) begin
                        gnt_idx_d   = winner_c;
                        gnt_valid_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                hold_cnt_d  = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase

        gnt_d = gnt_valid_d ? (N_REQ'(1) << gnt_idx_d) : '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            prio_q      <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed bench for rr_arbiter_4 built with MAX_HOLD=4.
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, reflecting the edge just taken.
module tb_rr_arbiter_4;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] eg,
                         input logic [1:0] ei, input logic ev, input logic et);
        logic [7:0] obs;
        logic [7:0] want;
        obs  = {gnt, gnt_idx, gnt_valid, timeout};
        want = {eg, ei, ev, et};
        n_checks++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed gnt=%b idx=%0d valid=%b timeout=%b, expected gnt=%b idx=%0d valid=%b timeout=%b",
                   tag, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
        end
    endtask

    // One-hot grant for owner o.
    function automatic logic [3:0] oh(input logic [1:0] o);
        return 4'b0001 << o;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] cur;
        logic [1:0] own;
        logic       to_exp;

        rst = 1'b0;
        ena = 1'b0;
        req = 4'b0000;
        tick();
        tick();
        check("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check("post_reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 1: single requester, two cycles of grant, then release.
        ena = 1'b1;
        req = 4'b0001;
        tick();
        check("t1_grant_c0", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        check("t1_grant_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        check("t1_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 2: prio=1 now, req=0101 alternates 2,0,2 every MAX_HOLD cycles.
        req = 4'b0101;
        for (int i = 0; i < 12; i++) begin
            tick();
            own    = (((i / 4) % 2) == 0) ? 2'd2 : 2'd0;
            to_exp = ((i % 4) == 0) && (i > 0);
            check($sformatf("t2_alt_%0d", i), oh(own), own, 1'b1, to_exp);
        end
        // Owner 2 at hold limit drops its request: plain release, no timeout.
        req = 4'b0000;
        tick();
        check("t2_drop_at_max", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 3: prio=3, all request; each owner drops after one cycle.
        req = 4'b1111;
        tick();
        cur = 2'd3;
        check("t3_first", oh(cur), cur, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            req = 4'b1111 & ~oh(cur);
            tick();
            cur = cur + 2'd1;
            check($sformatf("t3_rot_%0d", i), oh(cur), cur, 1'b1, 1'b0);
        end
        // cur ends at 0, so prio becomes 1.
        req = 4'b0000;
        tick();
        check("t3_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 4: lone requester 1 is regranted continuously with timeout pulses.
        req = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            tick();
            to_exp = ((i % 4) == 0) && (i > 0);
            check($sformatf("t4_solo_%0d", i), 4'b0010, 2'd1, 1'b1, to_exp);
        end
        req = 4'b0000;
        tick();
        check("t4_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 5: prio=2; owner 2 is released by ena=0, then prio=3 picks 1.
        req = 4'b0100;
        tick();
        check("t5_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        check("t5_hold2", 4'b0100, 2'd2, 1'b1, 1'b0);
        ena = 1'b0;
        tick();
        check("t5_ena_off", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0110;
        tick();
        check("t5_ena_off_1", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check("t5_ena_off_2", 4'b0000, 2'd0, 1'b0, 1'b0);
        ena = 1'b1;
        tick();
        check("t5_regrant1", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("t5_hold1_%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        // ena drops exactly at the hold limit: no timeout pulse.
        ena = 1'b0;
        tick();
        check("t5_ena_off_at_max", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 6: prio=2, req=0001 -> owner 0; async reset mid-cycle.
        ena = 1'b1;
        req = 4'b0001;
        tick();
        check("t6_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1010;
        tick();
        check("t6_in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        // prio back to 0: search 0,1 -> 1.
        tick();
        check("t6_prio_reset", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1000;
        tick();
        check("t6_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
Four-way round-robin arbiter that shares one resource (e.g. a board-row update port) among four requesters.
- Grant is presented both as a 2-bit index and as a one-hot vector. The one-hot vector is the 2-to-4 decode of the index, enabled by gnt_valid; decoder_2_to_4 may be instantiated for this.
- Sits between the requesting cell/row engines and the shared resource.
- Bounds each tenure with a hold timeout so no requester can starve the others.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (legal range 2..255).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
ena  input  1  arbiter enable; 0 = no new grants and current grant released
req  input  4  request vector, bit i = requester i wants the resource; held high for the whole tenure
gnt  output 4  one-hot grant; equals decode(gnt_idx) when gnt_valid=1, else 0000
gnt_idx  output 2  index of current owner; 0 when gnt_valid=0
gnt_valid  output 1  1 while a grant is held
timeout  output 1  one-cycle pulse: previous tenure ended because of MAX_HOLD

Behaviour:
Reset:
- Asynchronous assert forces state=IDLE, gnt=0000, gnt_idx=0, gnt_valid=0, timeout=0, prio=0, hold_cnt=0.
- Applies mid-tenure too: grant drops immediately, without waiting for a clock edge.
- Release is synchronous to clk.

Internal state:
- State is IDLE or BUSY.
- prio[1:0] is the highest-priority index.
- hold_cnt counts cycles of the current tenure; width ceil(log2(MAX_HOLD))+1.

Winner search:
- Order is prio, prio+1, prio+2, prio+3, mod 4 (3 wraps to 0).
- First requester found with req bit = 1 wins. Evaluated combinationally on the current req.

IDLE:
- If ena=1 and req!=0, the winner is registered: next cycle gnt_valid=1, gnt_idx=winner, hold_cnt=0, state=BUSY.
- Latency from req sampled high to gnt high is 1 cycle.
- Otherwise remain in IDLE with outputs 0.

BUSY, owner o. Release condition is any of:
- req[o]=0
- hold_cnt==MAX_HOLD-1 (grant held exactly MAX_HOLD cycles)
- ena=0

No release:
- hold_cnt increments; gnt is unchanged.

On release:
- prio <= o+1 mod 4.
- If ena=1 and req!=0, the winner is computed with the new prio (o searched last). It takes the grant on the next cycle with hold_cnt=0, no bubble cycle, state stays BUSY.
- Otherwise gnt goes to 0 next cycle and state=IDLE.

Timeout:
- Asserted for exactly the one cycle after a release whose cause included hold_cnt==MAX_HOLD-1 with req[o]=1 and ena=1.
- A release caused by ena=0 never pulses timeout.

Boundary cases:
- Timed-out owner is the only requester: it is regranted the next cycle with hold_cnt restarting at 0, and timeout pulses.
- req changes on non-owner bits during a tenure: ignored until release.
- req[o] drops on the same cycle hold_cnt hits MAX_HOLD-1: treated as normal release, timeout=0.
- gnt is always one-hot or zero, and matches gnt_idx/gnt_valid every cycle.

Test Plan:
1. Reset, ena=1, req=0001 held 2 cycles then 0000 -> gnt=0001 from 1 cycle after req rises, 2 cycles high, then 0000; gnt_idx=0; timeout never 1.
2. MAX_HOLD=4, req=0101 held constant -> gnt 0001 ×4, 0100 ×4, 0001 ×4 ... with no gap cycles; timeout pulses on the first cycle of each new tenure.
3. req=1111 each owner drops its req after 1 cycle of grant -> grant order 0,1,2,3,0; prio wraps 3->0.
4. MAX_HOLD=4, only req=0010 held -> gnt=0010 continuous, gnt_idx=1; timeout pulses every 4 cycles.
5. During tenure of owner 2 (req=0100), drive ena=0 for 3 cycles -> gnt=0000 next cycle, timeout=0. Restoring ena=1 with req=0110 -> gnt=1000? no: gnt=0100 is not chosen first; prio=3 so order 3,0,1,2 gives gnt=0010.
6. Assert rst=0 asynchronously mid-tenure -> gnt, gnt_idx, gnt_valid, timeout go to 0 before the next clk edge. After release with req=1000, the first grant is 1000 (prio reset to 0, search 0,1,2,3).
